// File: rtl/afu_cmd_credit_arbiter.sv
// afu_cmd_credit_arbiter
//   Credit-gated, fixed-priority command arbiter between the AFU command
//   buffers (0=WED 1=PF_WRITE 2=WRITE 3=PF_READ 4=READ) and the PSL command
//   issue stage. Requesters 1 and 2 draw on the write pool and the rest draw on
//   the read pool. A requester that has waited STARVE_LIMIT eligible cycles is
//   boosted ahead of the fixed order until it is granted.
// Ports
//   clock_i, reset_i          clock, synchronous active-high reset
//   req_valid_i/payload_i     per-requester command (payload i at [i*PAYLOAD_W +: PAYLOAD_W])
//   req_ready_o               one-hot grant, combinational, same cycle as selection
//   out_valid_o/ready_i       registered command toward PSL issue
//   out_payload_o/src_o       granted payload and requester index
//   out_is_write_o            granted command consumed a write credit
//   rsp_read/write_credit_i   one-credit return pulses
//   read/write_credits_o      credits available per pool
//   credit_error_o            sticky: a credit came back to a full pool
//   idle_o                    both pools full and nothing presented
module afu_cmd_credit_arbiter #(
  parameter int unsigned CREDITS_READ  = 32,
  parameter int unsigned CREDITS_WRITE = 32,
  parameter int unsigned PAYLOAD_W     = 128,
  parameter int unsigned STARVE_LIMIT  = 16,
  parameter int unsigned NUM_REQ       = 5,
  localparam int unsigned RD_W         = $clog2(CREDITS_READ + 1),
  localparam int unsigned WR_W         = $clog2(CREDITS_WRITE + 1)
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [PAYLOAD_W-1:0]         out_payload_o,
  output logic [2:0]                   out_src_o,
  output logic                         out_is_write_o,
  input  logic                         rsp_read_credit_i,
  input  logic                         rsp_write_credit_i,
  output logic [RD_W-1:0]              read_credits_o,
  output logic [WR_W-1:0]              write_credits_o,
  output logic                         credit_error_o,
  output logic                         idle_o
);

  localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);
  // Write-class requesters: PF_WRITE (1) and WRITE (2)
  localparam logic [NUM_REQ-1:0] WR_MASK = NUM_REQ'(6);

  logic [RD_W-1:0]      rd_q, rd_d;
  logic [WR_W-1:0]      wr_q, wr_d;
  logic                 err_q, err_d;
  logic                 idle_q, idle_d;
  logic                 out_valid_q, out_valid_d;
  logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;
  logic [2:0]           out_src_q, out_src_d;
  logic                 out_is_write_q, out_is_write_d;
  logic [AGE_W-1:0]     age_q [NUM_REQ];
  logic [AGE_W-1:0]     age_d [NUM_REQ];
  logic [NUM_REQ-1:0]   boost_q, boost_d;

  logic [NUM_REQ-1:0]   eligible;
  logic                 slot_free;
  logic                 found;
  logic                 grant_any;
  logic [2:0]           sel_idx;
  logic                 sel_wr;
  logic [PAYLOAD_W-1:0] sel_payload;
  logic [RD_W:0]        rd_sum;
  logic [WR_W:0]        wr_sum;
  logic                 rd_ovf, wr_ovf;

  // Selection: boosted eligible requester first, otherwise lowest eligible index
  always_comb begin
    eligible    = '0;
    found       = 1'b0;
    sel_idx     = '0;
    sel_wr      = 1'b0;
    sel_payload = '0;
    req_ready_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid_i[i] && (WR_MASK[i] ? (wr_q != '0) : (rd_q != '0));
    end
    slot_free = !out_valid_q || out_ready_i;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && eligible[i] && boost_q[i]) begin
        found   = 1'b1;
        sel_idx = 3'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && eligible[i]) begin
        found   = 1'b1;
        sel_idx = 3'(i);
      end
    end
    grant_any = found && slot_free && !reset_i;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == 3'(i)) begin
        sel_payload = req_payload_i[i*PAYLOAD_W +: PAYLOAD_W];
        sel_wr      = WR_MASK[i];
      end
      req_ready_o[i] = grant_any && (sel_idx == 3'(i));
    end
  end

  // Credit pools: debit on grant, credit on return, saturate and flag at full
  always_comb begin
    rd_sum = {1'b0, rd_q} + (RD_W+1)'(rsp_read_credit_i) - (RD_W+1)'(grant_any && !sel_wr);
    wr_sum = {1'b0, wr_q} + (WR_W+1)'(rsp_write_credit_i) - (WR_W+1)'(grant_any && sel_wr);
    rd_ovf = rd_sum > (RD_W+1)'(CREDITS_READ);
    wr_ovf = wr_sum > (WR_W+1)'(CREDITS_WRITE);
    rd_d   = rd_ovf ? RD_W'(CREDITS_READ) : rd_sum[RD_W-1:0];
    wr_d   = wr_ovf ? WR_W'(CREDITS_WRITE) : wr_sum[WR_W-1:0];
    err_d  = err_q || rd_ovf || wr_ovf;
  end

  // Starvation aging: count eligible-but-not-granted cycles, boost at the limit
  always_comb begin
    boost_d = boost_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      age_d[i] = age_q[i];
      if (req_ready_o[i] || !req_valid_i[i]) begin
        age_d[i] = '0;
      end else if (eligible[i] && (age_q[i] != AGE_W'(STARVE_LIMIT))) begin
        age_d[i] = AGE_W'(age_q[i] + 1'b1);
      end
      if (age_d[i] == AGE_W'(STARVE_LIMIT)) begin
        boost_d[i] = 1'b1;
      end
      if (req_ready_o[i]) begin
        boost_d[i] = 1'b0;
      end
    end
  end

  // Output stage: load on grant, drop on acceptance, hold while stalled
  always_comb begin
    out_valid_d    = out_valid_q;
    out_payload_d  = out_payload_q;
    out_src_d      = out_src_q;
    out_is_write_d = out_is_write_q;
    if (grant_any) begin
      out_valid_d    = 1'b1;
      out_payload_d  = sel_payload;
      out_src_d      = sel_idx;
      out_is_write_d = sel_wr;
    end else if (out_ready_i) begin
      out_valid_d    = 1'b0;
    end
    idle_d = (rd_d == RD_W'(CREDITS_READ)) && (wr_d == WR_W'(CREDITS_WRITE)) && !out_valid_d;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_q           <= RD_W'(CREDITS_READ);
      wr_q           <= WR_W'(CREDITS_WRITE);
      err_q          <= 1'b0;
      idle_q         <= 1'b1;
      out_valid_q    <= 1'b0;
      out_payload_q  <= '0;
      out_src_q      <= '0;
      out_is_write_q <= 1'b0;
      boost_q        <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      rd_q           <= rd_d;
      wr_q           <= wr_d;
      err_q          <= err_d;
      idle_q         <= idle_d;
      out_valid_q    <= out_valid_d;
      out_payload_q  <= out_payload_d;
      out_src_q      <= out_src_d;
      out_is_write_q <= out_is_write_d;
      boost_q        <= boost_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  assign out_valid_o     = out_valid_q;
  assign out_payload_o   = out_payload_q;
  assign out_src_o       = out_src_q;
  assign out_is_write_o  = out_is_write_q;
  assign read_credits_o  = rd_q;
  assign write_credits_o = wr_q;
  assign credit_error_o  = err_q;
  assign idle_o          = idle_q;

endmodule
